// File: rtl/lcd_init_sequencer.sv
// Power-on initialisation, configuration and user write sequencer for the Spartan-3E character LCD.
// Define LCD_CLEAR_ON_INIT_EN to append a clear-display command (and its extra wait) to the config bytes.
module lcd_init_sequencer #(
    parameter int T_POWERON = 750000,
    parameter int T_INIT1   = 205000,
    parameter int T_INIT2   = 5000,
    parameter int T_INIT3   = 2000,
    parameter int T_SETUP   = 2,
    parameter int T_E       = 12,
    parameter int CMD_WAIT  = 3200,
    parameter int T_CLEAR   = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       ready,
    output logic       init_done,
    output logic       cs_start,
    output logic       cs_rs,
    output logic       cs_rw,
    output logic [7:0] cs_data,
    input  logic       cs_lcd_rs,
    input  logic       cs_lcd_rw,
    input  logic       cs_lcd_e,
    input  logic [3:0] cs_sf_d,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] sf_d
);

`ifdef LCD_CLEAR_ON_INIT_EN
    localparam logic [1:0] LAST_CFG = 2'd3;
`else
    localparam logic [1:0] LAST_CFG = 2'd2;
`endif

    typedef enum logic [3:0] {
        S_PWR, S_NIB_SETUP, S_NIB_E, S_NIB_WAIT, S_CFG_START, S_CFG_WAIT,
`ifdef LCD_CLEAR_ON_INIT_EN
        S_CLR_WAIT,
`endif
        S_IDLE, S_USER_WAIT
    } state_t;

    state_t      state_q;
    logic [19:0] cnt_q;
    logic [1:0]  idx_q;
    logic [1:0]  cidx_q;
    logic [3:0]  nib_q;
    logic        e_q;
    logic        ready_q;
    logic        done_q;
    logic        start_q;
    logic        rs_q;
    logic [7:0]  data_q;
    logic [19:0] limit;
    logic        cnt_done;

    function automatic logic [3:0] nib_val(input logic [1:0] i);
        return (i == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [19:0] nib_wait(input logic [1:0] i);
        case (i)
            2'd0:    return 20'(T_INIT1);
            2'd1:    return 20'(T_INIT2);
            default: return 20'(T_INIT3);
        endcase
    endfunction

    function automatic logic [7:0] cfg_val(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    // The start-pulse cycle counts toward CMD_WAIT, so CFG_WAIT covers one cycle less.
    always_comb begin
        limit = 20'd1;
        case (state_q)
            S_PWR:       limit = 20'(T_POWERON);
            S_NIB_SETUP: limit = 20'(T_SETUP);
            S_NIB_E:     limit = 20'(T_E);
            S_NIB_WAIT:  limit = nib_wait(idx_q);
            S_CFG_WAIT:  limit = 20'(CMD_WAIT - 1);
`ifdef LCD_CLEAR_ON_INIT_EN
            S_CLR_WAIT:  limit = 20'(T_CLEAR);
`endif
            S_USER_WAIT: limit = 20'(CMD_WAIT);
            default:     limit = 20'd1;
        endcase
    end

    assign cnt_done = (cnt_q == limit - 20'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PWR;
            cnt_q   <= '0;
            idx_q   <= '0;
            cidx_q  <= '0;
            nib_q   <= '0;
            e_q     <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            start_q <= 1'b0;
            cnt_q   <= cnt_q + 20'd1;
            case (state_q)
                S_PWR: if (cnt_done) begin
                    state_q <= S_NIB_SETUP;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    nib_q   <= nib_val(2'd0);
                end
                S_NIB_SETUP: if (cnt_done) begin
                    state_q <= S_NIB_E;
                    cnt_q   <= '0;
                    e_q     <= 1'b1;
                end
                S_NIB_E: if (cnt_done) begin
                    state_q <= S_NIB_WAIT;
                    cnt_q   <= '0;
                    e_q     <= 1'b0;
                end
                S_NIB_WAIT: if (cnt_done) begin
                    cnt_q <= '0;
                    if (idx_q == 2'd3) begin
                        state_q <= S_CFG_START;
                        cidx_q  <= '0;
                        start_q <= 1'b1;
                        rs_q    <= 1'b0;
                        data_q  <= cfg_val(2'd0);
                    end else begin
                        state_q <= S_NIB_SETUP;
                        idx_q   <= idx_q + 2'd1;
                        nib_q   <= nib_val(idx_q + 2'd1);
                    end
                end
                S_CFG_START: begin
                    state_q <= S_CFG_WAIT;
                    cnt_q   <= '0;
                end
                S_CFG_WAIT: if (cnt_done) begin
                    cnt_q <= '0;
                    if (cidx_q == LAST_CFG) begin
`ifdef LCD_CLEAR_ON_INIT_EN
                        state_q <= S_CLR_WAIT;
`else
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= S_CFG_START;
                        cidx_q  <= cidx_q + 2'd1;
                        start_q <= 1'b1;
                        data_q  <= cfg_val(cidx_q + 2'd1);
                    end
                end
`ifdef LCD_CLEAR_ON_INIT_EN
                S_CLR_WAIT: if (cnt_done) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                end
`endif
                S_IDLE: begin
                    cnt_q <= '0;
                    if (req && ready_q) begin
                        state_q <= S_USER_WAIT;
                        ready_q <= 1'b0;
                        start_q <= 1'b1;
                        rs_q    <= rs;
                        data_q  <= data;
                    end
                end
                S_USER_WAIT: if (cnt_done) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_PWR;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // The bus belongs to the nibble driver only until the first config byte.
    always_comb begin
        lcd_rs = cs_lcd_rs;
        lcd_rw = cs_lcd_rw;
        lcd_e  = cs_lcd_e;
        sf_d   = cs_sf_d;
        if (state_q == S_PWR || state_q == S_NIB_SETUP ||
            state_q == S_NIB_E || state_q == S_NIB_WAIT) begin
            lcd_rs = 1'b0;
            lcd_rw = 1'b0;
            lcd_e  = e_q;
            sf_d   = nib_q;
        end
    end

    assign ready     = ready_q;
    assign init_done = done_q;
    assign cs_start  = start_q;
    assign cs_rs     = rs_q;
    assign cs_rw     = 1'b0;
    assign cs_data   = data_q;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Scoreboard bench for lcd_init_sequencer with a small behavioural command-sender model.
module tb_lcd_init_sequencer;
    localparam int T_POWERON = 40;
    localparam int T_INIT1   = 20;
    localparam int T_INIT2   = 10;
    localparam int T_INIT3   = 6;
    localparam int T_SETUP   = 2;
    localparam int T_E       = 3;
    localparam int CMD_WAIT  = 30;
    localparam int T_CLEAR   = 15;

`ifdef LCD_CLEAR_ON_INIT_EN
    localparam int NCFG = 4;
    localparam int DONE_AT = 237;
`else
    localparam int NCFG = 3;
    localparam int DONE_AT = 192;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, init_done, cs_start, cs_rs, cs_rw;
    logic [7:0] cs_data;
    logic       cs_lcd_rs, cs_lcd_rw, cs_lcd_e;
    logic [3:0] cs_sf_d;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [3:0] sf_d;

    lcd_init_sequencer #(
        .T_POWERON(T_POWERON), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_INIT3(T_INIT3),
        .T_SETUP(T_SETUP), .T_E(T_E), .CMD_WAIT(CMD_WAIT), .T_CLEAR(T_CLEAR)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .rs(rs), .data(data),
        .ready(ready), .init_done(init_done), .cs_start(cs_start), .cs_rs(cs_rs),
        .cs_rw(cs_rw), .cs_data(cs_data),
        .cs_lcd_rs(cs_lcd_rs), .cs_lcd_rw(cs_lcd_rw), .cs_lcd_e(cs_lcd_e), .cs_sf_d(cs_sf_d),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .sf_d(sf_d)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sender model: upper nibble latched at start, lower nibble read live from cs_data mid-transaction.
    logic       m_busy = 1'b0;
    int         m_cnt = 0;
    logic       m_rs = 1'b0;
    logic [3:0] m_hi = 4'h0;
    always @(posedge clk) begin
        if (cs_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_rs   <= cs_rs;
            m_hi   <= cs_data[7:4];
        end else if (m_busy) begin
            if (m_cnt == 20) m_busy <= 1'b0;
            else m_cnt <= m_cnt + 1;
        end
    end
    assign cs_lcd_e  = m_busy && ((m_cnt >= 2 && m_cnt <= 4) || (m_cnt >= 12 && m_cnt <= 14));
    assign cs_sf_d   = (m_cnt < 10) ? m_hi : cs_data[3:0];
    assign cs_lcd_rs = m_rs;
    assign cs_lcd_rw = 1'b0;

    typedef struct { logic rs; logic [7:0] d; int t; } start_t;
    typedef struct { logic [3:0] n; int t; } nib_t;
    typedef struct { logic rs; logic [7:0] d; } byte_t;
    start_t sq[$];
    nib_t   nq[$];
    byte_t  bq[$];
    int     rdyq[$];
    int     doneq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_init(input int base, input int ncfg, input bit full);
        logic [7:0] cfg [4];
        cfg[0] = 8'h28; cfg[1] = 8'h06; cfg[2] = 8'h0C; cfg[3] = 8'h01;
        nq.push_back('{4'h3, base + 42});
        nq.push_back('{4'h3, base + 67});
        nq.push_back('{4'h3, base + 82});
        nq.push_back('{4'h2, base + 93});
        for (int i = 0; i < ncfg; i++) begin
            sq.push_back('{1'b0, cfg[i], base + 102 + 30 * i});
            bq.push_back('{1'b0, cfg[i]});
        end
        if (full) begin
            rdyq.push_back(base + DONE_AT);
            doneq.push_back(base + DONE_AT);
        end
    endtask

    // Leaves rst low at a negedge; returns that cycle as the release base.
    task automatic do_reset(input int n, output int base);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("reset_outputs", int'({ready, init_done, cs_start, cs_rs, cs_rw, cs_data,
                                         lcd_rs, lcd_rw, lcd_e, sf_d}), 0);
        end
        rst  = 1'b0;
        base = cyc;
    endtask

    task automatic wait_init();
        int k;
        k = 0;
        while (!init_done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("init_done_reached", int'(init_done), 1);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_req", int'(ready), 1);
    endtask

    logic       seen_start = 1'b0;
    logic       nib_pulse = 1'b0;
    int         e_w = 0;
    logic       half = 1'b0;
    logic [3:0] hi = 4'h0;
    logic       brs = 1'b0;
    logic       e_prev = 1'b0, rdy_prev = 1'b0, done_prev = 1'b0;
    logic [3:0] sf_h1 = 4'h0, sf_h2 = 4'h0;
    start_t     s_e;
    nib_t       n_e;
    byte_t      b_e;
    int         t_e;

    always @(negedge clk) begin
        if (rst) begin
            seen_start = 1'b0;
            nib_pulse  = 1'b0;
            half       = 1'b0;
        end else begin
            if (cs_start) begin
                if (sq.size() == 0) check("extra_start", 1, 0);
                else begin
                    s_e = sq.pop_front();
                    check("start_rs", int'(cs_rs), int'(s_e.rs));
                    check("start_data", int'(cs_data), int'(s_e.d));
                    check("start_cycle", cyc, s_e.t);
                end
                seen_start = 1'b1;
            end
            if (!seen_start && lcd_e && !e_prev) begin
                if (nq.size() == 0) check("extra_nibble", 1, 0);
                else begin
                    n_e = nq.pop_front();
                    check("nib_value", int'(sf_d), int'(n_e.n));
                    check("nib_rise_cycle", cyc, n_e.t);
                    check("nib_setup_stable", int'(sf_h1 == sf_d && sf_h2 == sf_d), 1);
                end
                nib_pulse = 1'b1;
                e_w = 0;
            end
            if (nib_pulse) begin
                if (lcd_e) e_w++;
                else begin
                    check("nib_e_width", e_w, T_E);
                    nib_pulse = 1'b0;
                end
            end
            if (seen_start && lcd_e && !e_prev) begin
                if (!half) begin
                    hi = sf_d;
                    brs = lcd_rs;
                    half = 1'b1;
                end else begin
                    half = 1'b0;
                    if (bq.size() == 0) check("extra_lcd_byte", 1, 0);
                    else begin
                        b_e = bq.pop_front();
                        check("lcd_byte", int'({hi, sf_d}), int'(b_e.d));
                        check("lcd_rs", int'(brs), int'(b_e.rs));
                        check("lcd_rw", int'(lcd_rw), 0);
                    end
                end
            end
            if (ready && !rdy_prev) begin
                if (rdyq.size() == 0) check("extra_ready_rise", 1, 0);
                else begin
                    t_e = rdyq.pop_front();
                    check("ready_rise_cycle", cyc, t_e);
                end
            end
            if (init_done && !done_prev) begin
                if (doneq.size() == 0) check("extra_done_rise", 1, 0);
                else begin
                    t_e = doneq.pop_front();
                    check("init_done_cycle", cyc, t_e);
                end
            end
        end
        e_prev    = lcd_e;
        rdy_prev  = ready;
        done_prev = init_done;
        sf_h2     = sf_h1;
        sf_h1     = sf_d;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, s, e_seen;

        do_reset(5, base);
        push_init(base, NCFG, 1'b1);
        e_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lcd_e) e_seen = 1;
        end
        check("no_e_after_release", e_seen, 0);
        wait_init();

        // Single data write
        wait_ready();
        s = cyc;
        req = 1'b1; rs = 1'b1; data = 8'h41;
        sq.push_back('{1'b1, 8'h41, s + 1});
        bq.push_back('{1'b1, 8'h41});
        rdyq.push_back(s + 31);
        @(negedge clk);
        req = 1'b0;
        repeat (40) @(negedge clk);

        // req held high across three transactions
        wait_ready();
        s = cyc;
        req = 1'b1; rs = 1'b1; data = 8'h42;
        for (int i = 0; i < 3; i++) begin
            sq.push_back('{1'b1, 8'h42, s + 1 + 31 * i});
            bq.push_back('{1'b1, 8'h42});
            rdyq.push_back(s + 31 + 31 * i);
        end
        repeat (63) @(negedge clk);
        req = 1'b0;
        repeat (60) @(negedge clk);

        // Reset during the 0x06 command wait, then a full re-run
        do_reset(2, base);
        push_init(base, 2, 1'b0);
        repeat (157) @(negedge clk);
        do_reset(2, base);
        push_init(base, NCFG, 1'b1);
        wait_init();
        repeat (40) @(negedge clk);

        check("starts_left", sq.size(), 0);
        check("nibbles_left", nq.size(), 0);
        check("bytes_left", bq.size(), 0);
        check("ready_rises_left", rdyq.size(), 0);
        check("done_rises_left", doneq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_init_sequencer.md
# lcd_init_sequencer

Upstream controller for the Spartan-3E character LCD 4-bit interface. After reset it runs the power-on initialisation: timed nibble writes driven directly on the bus, then configuration bytes issued through the byte-level command sender. It then accepts character and command writes from user logic over a ready/req handshake. It also owns the LCD bus mux: its own nibble driver during power-on init, command-sender pass-through afterwards.

## Interface
- T_POWERON, 750000: cycles of idle wait after reset (15 ms at 50 MHz)
- T_INIT1, 205000: wait after nibble 0 (4.1 ms)
- T_INIT2, 5000: wait after nibble 1 (100 us)
- T_INIT3, 2000: wait after nibbles 2 and 3 (40 us)
- T_SETUP, 2: cycles sf_d is stable before lcd_e rises
- T_E, 12: lcd_e high width for init nibbles
- CMD_WAIT, 3200: cycles reserved per command-sender transaction, start pulse inclusive; must exceed the sender's 3104-cycle cycle
- T_CLEAR, 82000: extra wait after clear-display (1.64 ms)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- req  in  1  user write request
- rs  in  1  user register select (0 = command, 1 = data)
- data  in  8  user byte
- ready  out  1  high when a request will be accepted
- init_done  out  1  high once power-on init and config are complete; stays high until rst
- cs_start  out  1  one-cycle start pulse to the command sender
- cs_rs  out  1  rs to the command sender
- cs_rw  out  1  rw to the command sender; constant 0
- cs_data  out  8  byte to the command sender
- cs_lcd_rs, cs_lcd_rw, cs_lcd_e  in  1 each  command-sender bus outputs
- cs_sf_d  in  4  command-sender nibble output
- lcd_rs, lcd_rw, lcd_e  out  1 each  LCD pins
- sf_d  out  4  LCD data nibble

## Operation
- States:
  - PWR: count T_POWERON, then go to NIB_SETUP with idx = 0.
  - NIB_SETUP: sf_d = nibble[idx], lcd_e = 0, for T_SETUP cycles.
  - NIB_E: lcd_e = 1 for T_E cycles.
  - NIB_WAIT: lcd_e = 0, sf_d held, for the wait of nibble[idx]. Then idx++, or go to CFG_START with cidx = 0 after idx 3.
  - CFG_START: pulse cs_start with cs_rs = 0, cs_data = cfg[cidx].
  - CFG_WAIT: count CMD_WAIT, then cidx++ or go to CLR_WAIT/IDLE after the last byte.
  - CLR_WAIT: count T_CLEAR, then go to IDLE.
  - IDLE: ready = 1. Leave on accepted req.
  - USER_WAIT: count CMD_WAIT, then return to IDLE.
- Init nibbles are 0x3, 0x3, 0x3, 0x2. Their waits are T_INIT1, T_INIT2, T_INIT3, T_INIT3.
- Config bytes are 0x28 (function set), 0x06 (entry mode), 0x0C (display on), then 0x01 (clear) when configured.
- Mux:
  - In PWR and NIB_*: lcd_rs = 0, lcd_rw = 0, sf_d and lcd_e from internal registers.
  - In all other states: lcd_* and sf_d are combinational pass-through of the cs_* inputs.
- cs_rs and cs_data are registered. They are held constant from the start pulse until the next start pulse, because the sender samples the low nibble mid-transaction.
- A request is accepted when req && ready at a clk edge. rs and data are captured at that edge. req while ready = 0 is ignored and not queued.
- The cycle counter is 20 bits. It is cleared on every state entry, and each state leaves when count == limit − 1.

## Timing
- Reset values:
  - ready = 0, init_done = 0, cs_start = 0, cs_rs = 0, cs_rw = 0, cs_data = 0x00.
  - Internal nibble = 0 and internal e = 0, so lcd_rs = lcd_rw = lcd_e = 0 and sf_d = 0x0.
  - State = PWR.
- Reset mid-operation: same values on the next edge and init restarts from PWR. The command sender has no reset. T_POWERON > CMD_WAIT guarantees any in-flight sender transaction finishes before the mux hands it the bus.
- Request at edge k:
  - cs_start = 1 for the cycle after k only.
  - ready = 0 from k+1.
  - ready = 1 again at k+1+CMD_WAIT, so back-to-back requests are CMD_WAIT+1 cycles apart.
- init_done and ready rise on the same edge as IDLE entry.
- Reset to IDLE latency, with clear: T_POWERON + 4·(T_SETUP+T_E) + T_INIT1 + T_INIT2 + 2·T_INIT3 + 4·CMD_WAIT + T_CLEAR cycles.

## Configuration
- LCD_CLEAR_ON_INIT_EN
  - Defined: config issues 0x01 after 0x0C, then waits CMD_WAIT + T_CLEAR before IDLE.
  - Undefined: config ends after 0x0C and goes to IDLE directly after its CMD_WAIT; the CLR_WAIT state is absent.

## Test plan
Bench parameters: T_POWERON = 40, T_INIT1 = 20, T_INIT2 = 10, T_INIT3 = 6, T_SETUP = 2, T_E = 3, CMD_WAIT = 30, T_CLEAR = 15. A behavioural sender model is attached.

- **Reset hold:** rst high 5 cycles -> all outputs 0 and ready = 0 throughout; no lcd_e edge within 40 cycles of release.
- **Init nibbles:** after release -> exactly four lcd_e pulses, each 3 cycles wide, with sf_d = 3, 3, 3, 2 stable 2 cycles before each rise. Rise spacing is 25, 15, 11 cycles.
- **Config:** cs_start pulses with cs_data = 0x28, 0x06, 0x0C, 0x01, spaced 30 cycles apart. init_done rises 45 cycles after the 0x01 pulse; with the macro undefined, three bytes and 30 cycles.
- **User write:** req with rs = 1, data = 0x41 in IDLE -> cs_start one cycle later with cs_rs = 1, cs_data = 0x41. lcd_* mirrors the model, and ready returns after 30 cycles.
- **Req while busy:** hold req high continuously with data = 0x42 -> starts spaced exactly 31 cycles apart, and no extra start pulses.
- **Reset mid-config:** rst during the 0x06 wait -> outputs reset next edge; the full sequence restarts from PWR and completes correctly.
